// File: rtl/mux2_1_32.sv
// Write-back select mux with a registered, valid-qualified copy and a saturating
// memory-select counter. Define MUX2_1_32_PARITY_EN to add the registered parityReg output.
module mux2_1_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inMem,
    input  logic [WIDTH-1:0] inRes,
    input  logic             mMemSel,
    input  logic             inValid,
    output logic [WIDTH-1:0] mWrite,
    output logic [WIDTH-1:0] mWriteReg,
    output logic             validReg,
`ifdef MUX2_1_32_PARITY_EN
    output logic             parityReg,
`endif
    output logic [CNT_W-1:0] memSelCount
);

    // An if/else, not a ternary, so an unknown select falls through to inRes.
    always_comb begin
        mWrite = inRes;
        if (mMemSel) begin
            mWrite = inMem;
        end
    end

    // Valid semantics: a sample is accepted on any rising edge where inValid is 1
    // (no back-pressure); validReg marks that mWriteReg was loaded on the last edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mWriteReg <= '0;
            validReg  <= 1'b0;
        end else begin
            validReg <= inValid;
            if (inValid) begin
                mWriteReg <= mWrite;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memSelCount <= '0;
        end else if (inValid && mMemSel && (memSelCount != {CNT_W{1'b1}})) begin
            memSelCount <= memSelCount + 1'b1;
        end
    end

`ifdef MUX2_1_32_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parityReg <= 1'b0;
        end else if (inValid) begin
            parityReg <= ^mWrite;
        end
    end
`endif

endmodule

// File: tb/tb_mux2_1_32.sv
// Self-checking bench for mux2_1_32: combinational select, registered capture,
// async reset, counter saturation (second instance with CNT_W = 4), optional parity.
module tb_mux2_1_32;

    logic        clk;
    logic        reset;
    logic [31:0] inMem;
    logic [31:0] inRes;
    logic        mMemSel;
    logic        inValid;
    logic [31:0] mWrite;
    logic [31:0] mWriteReg;
    logic        validReg;
    logic [15:0] memSelCount;
    logic [31:0] mWriteB;
    logic [31:0] mWriteRegB;
    logic        validRegB;
    logic [3:0]  memSelCountB;
`ifdef MUX2_1_32_PARITY_EN
    logic        parityReg;
    logic        parityRegB;
`endif

    int compared;
    int mismatched;

    logic [31:0] expQ[$];
    logic [31:0] regModel;
    logic        validModel;
    logic        parModel;
    int          cnt16Model;
    int          cnt4Model;

    mux2_1_32 #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .inMem(inMem), .inRes(inRes),
        .mMemSel(mMemSel), .inValid(inValid), .mWrite(mWrite),
        .mWriteReg(mWriteReg), .validReg(validReg),
`ifdef MUX2_1_32_PARITY_EN
        .parityReg(parityReg),
`endif
        .memSelCount(memSelCount)
    );

    mux2_1_32 #(.WIDTH(32), .CNT_W(4)) dutSmall (
        .clk(clk), .reset(reset), .inMem(inMem), .inRes(inRes),
        .mMemSel(mMemSel), .inValid(inValid), .mWrite(mWriteB),
        .mWriteReg(mWriteRegB), .validReg(validRegB),
`ifdef MUX2_1_32_PARITY_EN
        .parityReg(parityRegB),
`endif
        .memSelCount(memSelCountB)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic resetModel();
        regModel   = '0;
        validModel = 1'b0;
        parModel   = 1'b0;
        cnt16Model = 0;
        cnt4Model  = 0;
        expQ.delete();
    endtask

    task automatic checkRegs(input string tag);
        checkEq({tag, ".mWriteReg"}, mWriteReg, regModel);
        checkEq({tag, ".validReg"}, {31'd0, validReg}, {31'd0, validModel});
        checkEq({tag, ".count16"}, {16'd0, memSelCount}, cnt16Model);
        checkEq({tag, ".count4"}, {28'd0, memSelCountB}, cnt4Model);
`ifdef MUX2_1_32_PARITY_EN
        checkEq({tag, ".parity"}, {31'd0, parityReg}, {31'd0, parModel});
`endif
    endtask

    // Drive one sample mid-cycle, push the expected capture, then compare after the edge.
    task automatic driveSample(input string tag, input logic v, input logic s,
                               input logic [31:0] m, input logic [31:0] r);
        logic [31:0] popped;
        inValid = v;
        mMemSel = s;
        inMem   = m;
        inRes   = r;
        if (v) expQ.push_back(s ? m : r);
        #1;
        checkEq({tag, ".mWrite"}, mWrite, s ? m : r);
        @(posedge clk);
        #1;
        if (v) begin
            if (expQ.size() == 0) begin
                checkEq({tag, ".queueEmpty"}, 32'd1, 32'd0);
            end else begin
                popped   = expQ.pop_front();
                regModel = popped;
                parModel = ^popped;
            end
            if (s) begin
                if (cnt16Model < 65535) cnt16Model++;
                if (cnt4Model < 15) cnt4Model++;
            end
        end
        validModel = v;
        checkRegs(tag);
    endtask

    initial begin
        logic        xSel;
        logic [31:0] held;
        compared   = 0;
        mismatched = 0;
        reset   = 1'b0;
        inValid = 1'b0;
        mMemSel = 1'b0;
        inMem   = '0;
        inRes   = '0;
        resetModel();
        #1 reset = 1'b1;
        #1;
        checkRegs("reset");

        // combinational select, several patterns
        inMem = 32'd500; inRes = 32'd400; mMemSel = 1'b0;
        #1 checkEq("comb.sel0", mWrite, 32'd400);
        mMemSel = 1'b1;
        #1 checkEq("comb.sel1", mWrite, 32'd500);
        for (int i = 0; i < 6; i++) begin
            inMem   = $urandom;
            inRes   = $urandom;
            mMemSel = 1'($urandom_range(0, 1));
            #0.5;
            checkEq("comb.rand", mWrite, mMemSel ? inMem : inRes);
        end
        inMem = 32'd500; inRes = 32'd400; mMemSel = 1'bx;
        xSel = mMemSel;
        #0.5 checkEq("comb.xsel", mWrite, (xSel === 1'b1) ? 32'd500 : 32'd400);
        mMemSel = 1'b0;

        // release reset; the very first edge must capture
        @(negedge clk);
        reset = 1'b0;
        driveSample("first", 1'b1, 1'b1, 32'hDEADBEEF, 32'h0);
        driveSample("hold", 1'b0, 1'b1, 32'h12345678, 32'h9);
        inMem = 32'hCAFEF00D; inValid = 1'b1;
        #2 checkEq("between.mWriteReg", mWriteReg, 32'hDEADBEEF);
        driveSample("res", 1'b1, 1'b0, 32'h11111111, 32'h22222222);
        driveSample("par1", 1'b1, 1'b1, 32'h00000007, 32'h0);
        driveSample("par0", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0);
        for (int i = 0; i < 12; i++) begin
            driveSample("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom, $urandom);
        end

        // async reset mid-cycle after captures
        driveSample("preRst", 1'b1, 1'b1, 32'hA5A5A5A5, 32'h0);
        inMem = 32'h0BADF00D; inRes = 32'h600D600D; mMemSel = 1'b1; inValid = 1'b1;
        #2 reset = 1'b1;
        #1;
        resetModel();
        checkRegs("asyncRst");
        checkEq("asyncRst.mWrite", mWrite, 32'h0BADF00D);
        mMemSel = 1'b0;
        #0.5 checkEq("asyncRst.mWriteRes", mWrite, 32'h600D600D);
        @(posedge clk);
        #1 checkRegs("rstHeld");
        @(negedge clk);
        reset = 1'b0;
        driveSample("afterRst", 1'b1, 1'b0, 32'h0, 32'h13572468);

        // counter saturation (small instance saturates at 15)
        for (int i = 0; i < 20; i++) begin
            driveSample("sat", 1'b1, 1'b1, $urandom, $urandom);
        end
        checkEq("sat.count4", {28'd0, memSelCountB}, 32'd15);
        held = {16'd0, memSelCount};
        driveSample("noIncSel0", 1'b1, 1'b0, $urandom, $urandom);
        driveSample("noIncInv", 1'b0, 1'b1, $urandom, $urandom);
        checkEq("noInc.count16", {16'd0, memSelCount}, held);
        checkEq("noInc.count4", {28'd0, memSelCountB}, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mux2_1_32.md
MUX2_1_32 -- requirements
Module: mux2_1_32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data path width of inMem, inRes, mWrite and mWriteReg.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of memSelCount.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; the clock port SHALL be named clk and the reset port reset.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port reset, input, 1: asynchronous active-high reset.
REQ-006 Port inMem, input, WIDTH: memory read data (write-back candidate).
REQ-007 Port inRes, input, WIDTH: ALU/result data (write-back candidate).
REQ-008 Port mMemSel, input, 1: select; 1 = memory, 0 = result.
REQ-009 Port inValid, input, 1: qualifies the sample for the registered stage.
REQ-010 Port mWrite, output, WIDTH: combinational write-back data.
REQ-011 Port mWriteReg, output, WIDTH: registered write-back data.
REQ-012 Port validReg, output, 1: mWriteReg holds a sample captured on the previous edge.
REQ-013 Port memSelCount, output, CNT_W: saturating count of accepted samples with mMemSel = 1.

Function
REQ-014 mWrite SHALL equal inMem when mMemSel = 1 and inRes when mMemSel = 0, with zero clock latency and no dependence on clk, reset or inValid.
REQ-015 When mMemSel is X or Z, mWrite SHALL equal inRes, so select 0 is the default.
REQ-016 On a rising clk edge with inValid = 1, mWriteReg SHALL load the current mWrite value and validReg SHALL become 1, giving one-cycle latency.
REQ-017 On a rising clk edge with inValid = 0, mWriteReg SHALL hold its value and validReg SHALL become 0.
REQ-018 On each edge with inValid = 1 and mMemSel = 1, memSelCount SHALL increment by 1 and saturate at 2^CNT_W - 1, with no wrap-around.
REQ-019 Input changes between edges SHALL affect only mWrite; registered outputs SHALL change only on an edge or on reset.

Reset
REQ-020 Asserting reset SHALL immediately set mWriteReg = 0, validReg = 0 and memSelCount = 0, without waiting for clk.
REQ-021 While reset is high, registered outputs SHALL stay at their reset values regardless of inValid, and mWrite SHALL keep following REQ-014.
REQ-022 On the first rising edge after reset deasserts, the block SHALL behave normally; a sample with inValid = 1 on that edge SHALL be captured.

Configuration
REQ-023 When macro MUX2_1_32_PARITY_EN is defined, the block SHALL add output parityReg (1 bit), registered alongside mWriteReg, equal to the even parity (XOR-reduce) of the captured data and reset to 0.
REQ-024 When MUX2_1_32_PARITY_EN is undefined, parityReg and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-025 Combinational select: inMem = 500, inRes = 400, mMemSel = 0 -> mWrite = 400; then mMemSel = 1 -> mWrite = 500, with no clock toggling.
REQ-026 Registered path: inValid = 1, mMemSel = 1, inMem = 32'hDEADBEEF -> after one edge mWriteReg = 32'hDEADBEEF and validReg = 1; next edge with inValid = 0 -> mWriteReg holds and validReg = 0.
REQ-027 Async reset: assert reset mid-cycle after captures -> mWriteReg = 0, validReg = 0 and memSelCount = 0 before the next edge, while mWrite still tracks its inputs.
REQ-028 Counter saturation with CNT_W = 4: 20 accepted samples with mMemSel = 1 -> memSelCount = 15; samples with mMemSel = 0 or inValid = 0 -> no increment.
REQ-029 Parity build: inMem = 32'h00000007, mMemSel = 1, inValid = 1 -> parityReg = 1 after one edge; with inRes = 0, mMemSel = 0 -> parityReg = 0.
REQ-030 X select: mMemSel = X, inRes = 400, inMem = 500 -> mWrite = 400.
